// File: rtl/debounce_defs.sv
// Shared definitions for the multi-channel debouncer: stability FSM encoding and
// default timing for a 100 MHz clk.
package debounce_defs;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_CHANGING = 1'b1
  } deb_state_e;

  localparam int unsigned DEF_CHANNELS      = 5;
  localparam int unsigned DEF_SYNC_STAGES   = 2;
  localparam int unsigned DEF_TICK_DIV      = 100000;
  localparam int unsigned DEF_STABLE_TICKS  = 10;
  localparam int unsigned DEF_REPEAT_EN     = 1;
  localparam int unsigned DEF_REPEAT_DELAY  = 500;
  localparam int unsigned DEF_REPEAT_PERIOD = 100;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: synchroniser, tick-based stability FSM, edge pulses and
// optional auto-repeat while held.
//   state       | meaning
//   ST_STABLE   | synchronised input matches the debounced level
//   ST_CHANGING | input differs from the level; counting ticks toward acceptance
module debounce_channel
  import debounce_defs::*;
#(
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned STABLE_TICKS  = DEF_STABLE_TICKS,
  parameter int unsigned REPEAT_EN     = DEF_REPEAT_EN,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_i,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic repeat_o
);

  localparam int unsigned STB_W = $clog2(STABLE_TICKS + 1);
  localparam int unsigned REP_W = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_TICKS - 1);
  localparam logic [REP_W-1:0] REP_DLY  = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] REP_PER  = REP_W'(REPEAT_PERIOD);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  deb_state_e             state_q, state_d;
  logic [STB_W-1:0]       stb_cnt_q, stb_cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   accept;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_STABLE;
      stb_cnt_q <= '0;
      level_q   <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      stb_cnt_q <= stb_cnt_d;
      level_q   <= level_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    stb_cnt_d = stb_cnt_q;
    case (state_q)
      ST_STABLE: begin
        if (s != level_q) begin
          state_d   = ST_CHANGING;
          stb_cnt_d = '0;
        end
      end
      ST_CHANGING: begin
        // A glitch back to the current level wins even on the accepting tick.
        if (s == level_q) begin
          state_d   = ST_STABLE;
          stb_cnt_d = '0;
        end else if (tick_i) begin
          if (stb_cnt_q == STB_LAST) begin
            state_d   = ST_STABLE;
            stb_cnt_d = '0;
          end else begin
            stb_cnt_d = stb_cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    accept  = (state_q == ST_CHANGING) && (s != level_q) && tick_i && (stb_cnt_q == STB_LAST);
    level_d = accept ? s : level_q;
    rise_d  = accept & s;
    fall_d  = accept & ~s;
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

  if (REPEAT_EN != 0) begin : g_rep
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d, rep_inc, rep_lim;
    logic             phase_q, phase_d;
    logic             rep_q, rep_d;

    always_comb begin
      rep_cnt_d = rep_cnt_q;
      phase_d   = phase_q;
      rep_d     = 1'b0;
      rep_inc   = rep_cnt_q + 1'b1;
      rep_lim   = phase_q ? REP_PER : REP_DLY;
      // Released, or the level is changing this cycle: restart from the delay phase.
      if (!level_q || accept) begin
        rep_cnt_d = '0;
        phase_d   = 1'b0;
      end else if (tick_i) begin
        if (rep_inc == rep_lim) begin
          rep_cnt_d = '0;
          phase_d   = 1'b1;
          rep_d     = 1'b1;
        end else begin
          rep_cnt_d = rep_inc;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        rep_cnt_q <= '0;
        phase_q   <= 1'b0;
        rep_q     <= 1'b0;
      end else begin
        rep_cnt_q <= rep_cnt_d;
        phase_q   <= phase_d;
        rep_q     <= rep_d;
      end
    end

    assign repeat_o = rep_q;
  end else begin : g_no_rep
    assign repeat_o = 1'b0;
  end

endmodule

// File: rtl/multi_debounce.sv
// N-channel button debouncer: one shared tick prescaler feeding independent
// per-channel debouncers.
module multi_debounce
  import debounce_defs::*;
#(
  parameter int unsigned CHANNELS      = DEF_CHANNELS,
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned TICK_DIV      = DEF_TICK_DIV,
  parameter int unsigned STABLE_TICKS  = DEF_STABLE_TICKS,
  parameter int unsigned REPEAT_EN     = DEF_REPEAT_EN,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] repeat_pulse,
  output logic                tick
);

  localparam int unsigned DIV_W = $clog2(TICK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
    $error("multi_debounce: CHANNELS must be 1..32");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("multi_debounce: SYNC_STAGES must be >= 2");
  end
  if (TICK_DIV < 1 || STABLE_TICKS < 1) begin : g_bad_timing
    $error("multi_debounce: TICK_DIV and STABLE_TICKS must be >= 1");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("multi_debounce: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             div_wrap;

  assign div_wrap  = (div_cnt_q == DIV_LAST);
  assign div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) div_cnt_q <= '0;
    else       div_cnt_q <= div_cnt_d;
  end

  // Masked during reset so the exported tick is quiet like every other output.
  assign tick = div_wrap & ~reset;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_TICKS (STABLE_TICKS),
      .REPEAT_EN    (REPEAT_EN),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .tick_i  (tick),
      .btn_i   (btn_in[i]),
      .level_o (btn_level[i]),
      .rise_o  (rise[i]),
      .fall_o  (fall[i]),
      .repeat_o(repeat_pulse[i])
    );
  end

endmodule

// File: tb/tb_multi_debounce.sv
// Randomised and directed bench for multi_debounce against a tick-arithmetic
// reference model; a second instance is built with auto-repeat disabled.
module tb_multi_debounce;

  localparam int CH = 2;
  localparam int SY = 2;
  localparam int D  = 4;
  localparam int ST = 3;
  localparam int RD = 4;
  localparam int RP = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CH-1:0] btn_in = '0;
  logic [CH-1:0] lvl1, rise1, fall1, rep1;
  logic [CH-1:0] lvl2, rise2, fall2, rep2;
  logic          tick1, tick2;

  always #5 clk = ~clk;

  multi_debounce #(
    .CHANNELS(CH), .SYNC_STAGES(SY), .TICK_DIV(D), .STABLE_TICKS(ST),
    .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in), .btn_level(lvl1), .rise(rise1),
    .fall(fall1), .repeat_pulse(rep1), .tick(tick1)
  );

  multi_debounce #(
    .CHANNELS(CH), .SYNC_STAGES(SY), .TICK_DIV(D), .STABLE_TICKS(ST),
    .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_norep (
    .clk(clk), .reset(reset), .btn_in(btn_in), .btn_level(lvl2), .rise(rise2),
    .fall(fall2), .repeat_pulse(rep2), .tick(tick2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: edge count since reset release, tick = every D-th edge.
  int            n;
  logic [CH-1:0] hist[$];
  logic [CH-1:0] m_level, m_rise, m_fall, m_rep, m_pend;
  logic          m_tick;
  int            start[CH];
  int            rstart[CH];

  // Event counters over the current directed segment.
  int ev_rise[CH], ev_fall[CH], ev_rep[CH], ev_rep2[CH];

  task automatic clr_ev();
    for (int c = 0; c < CH; c++) begin
      ev_rise[c] = 0; ev_fall[c] = 0; ev_rep[c] = 0; ev_rep2[c] = 0;
    end
  endtask

  task automatic model_edge();
    logic [CH-1:0] s;
    m_rise = '0; m_fall = '0; m_rep = '0;
    if (reset) begin
      n = 0; hist.delete(); m_level = '0; m_pend = '0; m_tick = 1'b0;
      return;
    end
    n++;
    s = (hist.size() >= SY) ? hist[hist.size() - SY] : '0;
    hist.push_back(btn_in);
    if (hist.size() > SY) void'(hist.pop_front());
    for (int c = 0; c < CH; c++) begin
      logic was_hi;
      logic accepted;
      int   t;
      was_hi = m_level[c];
      accepted = 1'b0;
      if (!m_pend[c]) begin
        if (s[c] != m_level[c]) begin
          m_pend[c] = 1'b1;
          start[c] = n;
        end
      end else if (s[c] == m_level[c]) begin
        m_pend[c] = 1'b0;
      end else if (n % D == 0 && (n / D - start[c] / D) == ST) begin
        accepted = 1'b1;
        m_pend[c] = 1'b0;
        m_level[c] = s[c];
        m_rise[c] = s[c];
        m_fall[c] = ~s[c];
        if (s[c]) rstart[c] = n;
      end
      if (was_hi && !accepted && n % D == 0) begin
        t = (n - rstart[c]) / D;
        if (t == RD || (t > RD && (t - RD) % RP == 0)) m_rep[c] = 1'b1;
      end
    end
    m_tick = (n % D == D - 1);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("level", 32'(lvl1), 32'(m_level));
    chk("rise", 32'(rise1), 32'(m_rise));
    chk("fall", 32'(fall1), 32'(m_fall));
    chk("repeat", 32'(rep1), 32'(m_rep));
    chk("tick", 32'(tick1), 32'(m_tick));
    chk("norep_level", 32'(lvl2), 32'(m_level));
    chk("norep_repeat", 32'(rep2), 32'h0);
    for (int c = 0; c < CH; c++) begin
      ev_rise[c] += int'(rise1[c]);
      ev_fall[c] += int'(fall1[c]);
      ev_rep[c]  += int'(rep1[c]);
      ev_rep2[c] += int'(rep2[c]);
    end
  endtask

  task automatic run(input int cycles);
    repeat (cycles) step();
  endtask

  task automatic wait_rise0(input string tag, input int expect_lat);
    int lat;
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      step();
      if (rise1[0]) lat = k;
    end
    chk(tag, 32'(lat), 32'(expect_lat));
  endtask

  initial begin
    clr_ev();
    // Reset with both buttons held.
    btn_in = 2'b11;
    reset = 1'b1;
    run(3);
    reset = 1'b0;
    step();
    chk("first_edge_zero", {lvl1, rise1, fall1, rep1, 24'(tick1)}, 32'h0);
    wait_rise0("startup_latency", 11);
    run(10);
    btn_in = 2'b00;
    run(30);

    // Short glitch on channel 0 (fewer than STABLE_TICKS ticks).
    clr_ev();
    btn_in = 2'b01;
    run(6);
    btn_in = 2'b00;
    run(20);
    chk("glitch_rise", 32'(ev_rise[0]), 32'd0);
    chk("glitch_fall", 32'(ev_fall[0]), 32'd0);

    // Press and release channel 0.
    clr_ev();
    btn_in = 2'b01;
    run(40);
    btn_in = 2'b00;
    run(30);
    chk("press_rise", 32'(ev_rise[0]), 32'd1);
    chk("press_fall", 32'(ev_fall[0]), 32'd1);
    chk("press_ch1_quiet", 32'(ev_rise[1] + ev_fall[1] + ev_rep[1]), 32'd0);

    // Auto-repeat on channel 1: level high for exactly 80 cycles, repeats at +16, +24 .. +72.
    clr_ev();
    btn_in = 2'b10;
    run(80);
    btn_in = 2'b00;
    run(40);
    chk("rep_rise", 32'(ev_rise[1]), 32'd1);
    chk("rep_fall", 32'(ev_fall[1]), 32'd1);
    chk("rep_count", 32'(ev_rep[1]), 32'd8);

    // Reset in the middle of a CHANGING count.
    clr_ev();
    btn_in = 2'b01;
    run(8);
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    chk("midrst_no_pulse", 32'(ev_rise[0] + ev_fall[0]), 32'd0);
    wait_rise0("midrst_latency", 12);
    btn_in = 2'b00;
    run(30);

    // Randomised inputs with occasional resets.
    for (int k = 0; k < 150; k++) begin
      btn_in = CH'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) begin
        reset = 1'b1;
        run(int'($urandom_range(1, 3)));
        reset = 1'b0;
      end
      run(int'($urandom_range(1, 20)));
    end

    // Long hold: repeat-disabled build stays silent.
    btn_in = 2'b00;
    run(30);
    clr_ev();
    btn_in = 2'b11;
    run(200);
    chk("norep_hold", 32'(ev_rep2[0] + ev_rep2[1]), 32'd0);
    chk("rep_hold_active", 32'(ev_rep[0] > 0), 32'd1);
    btn_in = 2'b00;
    run(30);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
